// File: rtl/mem_lsu_pkg.sv
// Shared load/store unit types: RISC-V funct3 access codes, access sizes and FSM states.
package lsu_op_enum;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   // Only the low two funct3 bits carry size; 011/110/111 fall through to a word.
   function automatic lsu_size_e op_size(input logic [2:0] op);
      case (op[1:0])
         2'b00:   op_size = SZ_B;
         2'b01:   op_size = SZ_H;
         default: op_size = SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: combinational byte-lane steering for the LSU (byte enables, store
// replication, load extraction with sign/zero extension, misalignment detect).
module mem_align
   import lsu_op_enum::*;
(
   input  logic [1:0]  addr_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rd_data_i,
   output logic [3:0]  be_o,
   output logic [31:0] st_data_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o
);

   lsu_size_e   size;
   logic [1:0]  lane;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      size       = op_size(op_i);
      misalign_o = ((size == SZ_H) && addr_i[0]) || ((size == SZ_W) && (addr_i != 2'b00));
      // Lane is forced to the natural alignment of the access size.
      case (size)
         SZ_H:    lane = {addr_i[1], 1'b0};
         SZ_W:    lane = 2'b00;
         default: lane = addr_i;
      endcase
      byte_sel = rd_data_i[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rd_data_i[31:16] : rd_data_i[15:0];
      case (size)
         SZ_B: begin
            be_o      = 4'b0001 << lane;
            st_data_o = {4{st_data_i[7:0]}};
            ld_data_o = op_i[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_H: begin
            be_o      = 4'b0011 << {lane[1], 1'b0};
            st_data_o = {2{st_data_i[15:0]}};
            ld_data_o = op_i[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         default: begin
            be_o      = 4'b1111;
            st_data_o = st_data_i;
            ld_data_o = rd_data_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit with req/ack data bus.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned accesses without a bus cycle.
module mem_lsu
   import lsu_op_enum::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              mem_rd_en_i,
   input  logic              mem_wr_en_i,
   input  logic [2:0]        mem_op_sel_i,
   input  logic [XLEN-1:0]   alu_data_i,
   input  logic [XLEN-1:0]   rs2_rd_data_i,
   output logic              lsu_busy_o,
   output logic              lsu_done_o,
   output logic [XLEN-1:0]   lsu_data_o,
   output logic              lsu_misalign_o,
   output logic              bus_req_o,
   output logic              bus_wr_o,
   output logic [XLEN-1:0]   bus_addr_o,
   output logic [XLEN/8-1:0] bus_be_o,
   output logic [XLEN-1:0]   bus_wr_data_o,
   input  logic              bus_ack_i,
   input  logic [XLEN-1:0]   bus_rd_data_i
);

   lsu_state_e      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [2:0]      op_q, op_d;
   logic            wr_q, wr_d;
   logic            mis_q, mis_d;

   logic            req;
   logic            bus_active;
   logic            trap_now;
   logic [1:0]      a_addr;
   logic [2:0]      a_op;
   logic [3:0]      a_be;
   logic [31:0]     a_st;
   logic [31:0]     a_ld;
   logic            a_mis;

   assign req        = mem_rd_en_i | mem_wr_en_i;
   assign bus_active = (state_q == ST_BUS);

   // In IDLE the aligner looks at the incoming request so misalignment is known before accept.
   assign a_addr = (state_q == ST_IDLE) ? alu_data_i[1:0] : addr_q[1:0];
   assign a_op   = (state_q == ST_IDLE) ? mem_op_sel_i    : op_q;

   mem_align u_align (
      .addr_i     (a_addr),
      .op_i       (a_op),
      .st_data_i  (wdata_q),
      .rd_data_i  (bus_rd_data_i),
      .be_o       (a_be),
      .st_data_o  (a_st),
      .ld_data_o  (a_ld),
      .misalign_o (a_mis)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_now = a_mis;
`else
   logic unused_a_mis;
   assign unused_a_mis = a_mis;
   assign trap_now     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      op_d    = op_q;
      wr_d    = wr_q;
      mis_d   = mis_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = alu_data_i;
               wdata_d = rs2_rd_data_i;
               op_d    = mem_op_sel_i;
               wr_d    = mem_wr_en_i;
               mis_d   = trap_now;
               state_d = trap_now ? ST_DONE : ST_BUS;
            end
         end
         ST_BUS: begin
            if (bus_ack_i) begin
               if (!wr_q) data_d = a_ld;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         op_q    <= '0;
         wr_q    <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         op_q    <= op_d;
         wr_q    <= wr_d;
         mis_q   <= mis_d;
      end
   end

   // Bus outputs are gated by state so reset drops them without waiting for a clock.
   assign bus_req_o      = bus_active;
   assign bus_wr_o       = bus_active & wr_q;
   assign bus_addr_o     = bus_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign bus_be_o       = bus_active ? a_be : '0;
   assign bus_wr_data_o  = bus_active ? a_st : '0;
   assign lsu_busy_o     = ((state_q == ST_IDLE) & req) | bus_active;
   assign lsu_done_o     = (state_q == ST_DONE);
   assign lsu_misalign_o = (state_q == ST_DONE) & mis_q;
   assign lsu_data_o     = data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed + randomized bench for mem_lsu against a byte-arithmetic reference model.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        mem_rd_en_i, mem_wr_en_i;
   logic [2:0]  mem_op_sel_i;
   logic [31:0] alu_data_i, rs2_rd_data_i;
   logic        lsu_busy_o, lsu_done_o, lsu_misalign_o;
   logic [31:0] lsu_data_o;
   logic        bus_req_o, bus_wr_o;
   logic [31:0] bus_addr_o, bus_wr_data_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
   logic [31:0] bus_rd_data_i;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_data;

   mem_lsu #(.XLEN(32)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .mem_rd_en_i    (mem_rd_en_i),
      .mem_wr_en_i    (mem_wr_en_i),
      .mem_op_sel_i   (mem_op_sel_i),
      .alu_data_i     (alu_data_i),
      .rs2_rd_data_i  (rs2_rd_data_i),
      .lsu_busy_o     (lsu_busy_o),
      .lsu_done_o     (lsu_done_o),
      .lsu_data_o     (lsu_data_o),
      .lsu_misalign_o (lsu_misalign_o),
      .bus_req_o      (bus_req_o),
      .bus_wr_o       (bus_wr_o),
      .bus_addr_o     (bus_addr_o),
      .bus_be_o       (bus_be_o),
      .bus_wr_data_o  (bus_wr_data_o),
      .bus_ack_i      (bus_ack_i),
      .bus_rd_data_i  (bus_rd_data_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access; the core holds the enables until done is seen.
   task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int waits);
      int          sz, lane;
      logic        mis, trap;
      logic [3:0]  ebe;
      logic [31:0] ewd, eld, mask;
      sz   = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
      mis  = (addr % sz) != 0;
      lane = (addr % 4) / sz * sz;
      ebe  = 4'(((1 << sz) - 1) << lane);
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = rs2[8*(i % sz) +: 8];
      mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*sz)) - 32'd1;
      eld  = (rdata >> (8*lane)) & mask;
      if (!op[2] && sz < 4 && eld[8*sz-1]) eld = eld | ~mask;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = mis;
`else
      trap = 1'b0;
`endif
      mem_rd_en_i   = rd;
      mem_wr_en_i   = wr;
      mem_op_sel_i  = op;
      alu_data_i    = addr;
      rs2_rd_data_i = rs2;
      #1;
      check("busy_accept", {31'd0, lsu_busy_o}, 32'd1);
      @(negedge clk);
      if (!trap) begin
         for (int w = 0; w <= waits; w++) begin
            check("bus_req", {31'd0, bus_req_o}, 32'd1);
            check("bus_wr", {31'd0, bus_wr_o}, {31'd0, wr});
            check("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
            check("bus_be", {28'd0, bus_be_o}, {28'd0, ebe});
            if (wr) check("bus_wr_data", bus_wr_data_o, ewd);
            check("busy_bus", {31'd0, lsu_busy_o}, 32'd1);
            check("done_early", {31'd0, lsu_done_o}, 32'd0);
            bus_ack_i     = (w == waits);
            bus_rd_data_i = (w == waits) ? rdata : $urandom;
            @(negedge clk);
         end
         bus_ack_i = 1'b0;
         if (!wr) exp_data = eld;
      end
      check("done", {31'd0, lsu_done_o}, 32'd1);
      check("data", lsu_data_o, exp_data);
      check("misalign", {31'd0, lsu_misalign_o}, {31'd0, trap});
      check("req_in_done", {31'd0, bus_req_o}, 32'd0);
      check("busy_done", {31'd0, lsu_busy_o}, 32'd0);
      mem_rd_en_i = 1'b0;
      mem_wr_en_i = 1'b0;
      @(negedge clk);
      check("done_pulse", {31'd0, lsu_done_o}, 32'd0);
      check("req_idle", {31'd0, bus_req_o}, 32'd0);
   endtask

   initial begin
      rst_n_i       = 1'b0;
      mem_rd_en_i   = 1'b0;
      mem_wr_en_i   = 1'b0;
      mem_op_sel_i  = 3'd0;
      alu_data_i    = 32'd0;
      rs2_rd_data_i = 32'd0;
      bus_ack_i     = 1'b0;
      bus_rd_data_i = 32'd0;
      exp_data      = 32'd0;
      @(negedge clk);
      @(negedge clk);
      check("rst_req", {31'd0, bus_req_o}, 32'd0);
      check("rst_wr", {31'd0, bus_wr_o}, 32'd0);
      check("rst_done", {31'd0, lsu_done_o}, 32'd0);
      check("rst_mis", {31'd0, lsu_misalign_o}, 32'd0);
      check("rst_addr", bus_addr_o, 32'd0);
      check("rst_be", {28'd0, bus_be_o}, 32'd0);
      check("rst_wdata", bus_wr_data_o, 32'd0);
      check("rst_data", lsu_data_o, 32'd0);
      rst_n_i = 1'b1;
      @(negedge clk);

      access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
      check("lw_const", lsu_data_o, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0);
      check("lb_const", lsu_data_o, 32'hFFFF_FF80);
      access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
      check("lbu_const", lsu_data_o, 32'h0000_0080);
      access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 3);
      check("sh_keeps_data", lsu_data_o, 32'h0000_0080);
      access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0);
      access(1'b1, 1'b1, 3'b000, 32'h5, 32'h77, 32'h0, 0);
      check("both_store_wins", lsu_data_o, exp_data);

      // Stray ack while idle must not start or finish anything.
      bus_ack_i = 1'b1;
      @(negedge clk);
      bus_ack_i = 1'b0;
      check("stray_ack_done", {31'd0, lsu_done_o}, 32'd0);
      check("stray_ack_req", {31'd0, bus_req_o}, 32'd0);

      // Reset in the middle of a bus cycle.
      mem_rd_en_i  = 1'b1;
      mem_op_sel_i = 3'b010;
      alu_data_i   = 32'h300;
      @(negedge clk);
      check("pre_rst_req", {31'd0, bus_req_o}, 32'd1);
      #2 rst_n_i = 1'b0;
      mem_rd_en_i = 1'b0;
      #1;
      check("async_req_drop", {31'd0, bus_req_o}, 32'd0);
      check("rst_busy", {31'd0, lsu_busy_o}, 32'd0);
      @(negedge clk);
      rst_n_i  = 1'b1;
      exp_data = 32'd0;
      @(negedge clk);
      check("post_rst_done", {31'd0, lsu_done_o}, 32'd0);
      check("post_rst_data", lsu_data_o, 32'd0);
      access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BAD_CAFE, 0);
      check("post_rst_lw", lsu_data_o, 32'h0BAD_CAFE);

      for (int k = 0; k < 60; k++) begin
         int sel;
         sel = $urandom_range(0, 2);
         access(sel != 1, sel != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
